mem_load_controller: RTL and testbench
======================================

# mem_load_controller

Loader stage between an input token FIFO and a single-port RAM. On a start request it drains a snapshot of the FIFO population into the RAM, writing token k to address k. One instance serves the command path and one the data path of the polynomial evaluation accelerator. RAM contents are then read by downstream logic.

## Interface
- `word_size`, default 16, token width in bits.
- `buffer_size`, default 1024, FIFO depth and RAM depth; `AW = log2(buffer_size)` (10 for the default).

Ports:
- `clk`  in  1  clock; every transition is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low (0 = reset).
- `FIFO_population`  in  AW  current FIFO occupancy.
- `input_token`  in  word_size  FIFO head data; valid one cycle after `FIFO_rd_en` is sampled high.
- `start_in`  in  1  level-sensitive load request.
- `FIFO_rd_en`  out  1  FIFO pop strobe.
- `ram_wr_en`  out  1  RAM write strobe.
- `ram_wr_addr`  out  AW  RAM write address.
- `output_token`  out  word_size  RAM write data.

## Operation
- FSM states: IDLE, READ, WAIT, WRITE, END.
- IDLE
  - If `start_in`=1 and `FIFO_population`≠0: latch `count`=`FIFO_population`, clear `index`, go to READ.
  - Otherwise stay in IDLE.
- READ: `FIFO_rd_en`=1 for exactly one cycle, then go to WAIT.
- WAIT: register `input_token` into `output_token`, then go to WRITE.
- WRITE: `ram_wr_en`=1 with `ram_wr_addr`=`index`.
  - If `index`==`count`-1: go to END.
  - Otherwise increment `index` and go to READ.
- END: hold until `start_in`=0, then clear `index` and go to IDLE. Holding start high never triggers a second load.
- Count is a snapshot. Tokens that arrive in the FIFO after the snapshot stay in the FIFO for the next load.
- Every load writes from address 0. Address range is 0..`count`-1, and `count` ≤ 2^AW−1, so the address never wraps.
- `FIFO_rd_en` and `ram_wr_en` are never high in the same cycle.

## Timing
- Reset values: state IDLE; `FIFO_rd_en`=0, `ram_wr_en`=0, `ram_wr_addr`=0, `output_token`=0; `count`=0, `index`=0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Latency
  - `start_in` sampled at edge t gives READ at t+1.
  - Each token takes 3 cycles (READ, WAIT, WRITE).
  - The last write completes at edge t+3N; END is entered at the same edge.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0. A partial load is not resumed. RAM contents already written are kept.
- An empty FIFO at start keeps the block in IDLE and re-evaluates every cycle while `start_in` stays high.

## Configuration
- `MEM_LOAD_DONE_EN` defined:
  - Adds output `done` (1 bit, reset 0).
  - `done` is high for every cycle spent in END.
- Not defined: the port is absent and behaviour is otherwise identical.

## Structure
- Shared package `mem_load_pkg`:
  - state enum (IDLE, READ, WAIT, WRITE, END);
  - `log2` constant function;
  - default `word_size` and `buffer_size` constants.
- Single module with the FSM and the `index`/`count` registers inline. No sub-module.
- `fifo` and `single_port_ram` are external. The RAM samples `ram_wr_en`, `ram_wr_addr` and `output_token` on `clk`.

## Test plan
- Push 10, 20, 30 into the FIFO, then hold `start_in` high for 50 cycles. Expect RAM[0..2]=10, 20, 30, exactly 3 `FIFO_rd_en` pulses, and END reached 9 cycles after start.
- Push 100, 200, 300, 400, 500, 600. Expect RAM[0..5]=100..600 in order, with `ram_wr_addr` following 0..5.
- `start_in`=1 with FIFO empty. Expect no `FIFO_rd_en`, no `ram_wr_en`, state stays IDLE.
- After a 3-token load with `start_in` still high, push 7 and 8. Expect no writes until `start_in` drops and rises again; then RAM[0]=7, RAM[1]=8.
- Drop `rst` to 0 during the second WRITE of a 6-token load. Expect all outputs 0 immediately, RAM[0..1] kept, RAM[2..5] unchanged.
- Push 5 tokens during a 3-token load. Expect only 3 writes, leaving 5 tokens in the FIFO.

Source files
------------

// File: rtl/mem_load_pkg.sv
// mem_load_pkg
//   Shared definitions for mem_load_controller: FSM state encoding, a
//   ceil-log2 constant function used to size addresses, and the default
//   token width / buffer depth.
package mem_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    END
  } state_e;

  localparam int unsigned DEFAULT_WORD_SIZE   = 16;
  localparam int unsigned DEFAULT_BUFFER_SIZE = 1024;

  // Ceiling log2; returns at least 1 so address buses never collapse to 0 bits.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_load_controller.sv
// mem_load_controller
//   Drains a snapshot of an input token FIFO into a single-port RAM, writing
//   token k to address k. A load starts when start_in is high and the FIFO
//   is non-empty; each token takes READ (pop), WAIT (capture head data) and
//   WRITE (RAM strobe). After the last write the block parks in END until
//   start_in drops, so a held request never triggers a second load.
//
//   Ports:
//     clk              clock, rising edge
//     rst              asynchronous reset, active low
//     FIFO_population  FIFO occupancy, latched as the load length at start
//     input_token      FIFO head data, valid one cycle after a sampled pop
//     start_in         level-sensitive load request
//     FIFO_rd_en       FIFO pop strobe
//     ram_wr_en        RAM write strobe
//     ram_wr_addr      RAM write address
//     output_token     RAM write data
//     done             (only with MEM_LOAD_DONE_EN) high while in END
//
//   Build option: define MEM_LOAD_DONE_EN to add the done output.
module mem_load_controller
  import mem_load_pkg::*;
#(
  parameter  int unsigned word_size   = DEFAULT_WORD_SIZE,
  parameter  int unsigned buffer_size = DEFAULT_BUFFER_SIZE,
  localparam int unsigned AW          = log2(buffer_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        FIFO_population,
  input  logic [word_size-1:0] input_token,
  input  logic                 start_in,
  output logic                 FIFO_rd_en,
  output logic                 ram_wr_en,
  output logic [AW-1:0]        ram_wr_addr,
  output logic [word_size-1:0] output_token
`ifdef MEM_LOAD_DONE_EN
  ,
  output logic                 done
`endif
);

  state_e               state_q, state_d;
  logic [AW-1:0]        count_q, count_d;
  logic [AW-1:0]        index_q, index_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [word_size-1:0] token_q, token_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    token_d = token_q;

    case (state_q)
      IDLE: begin
        if (start_in && (FIFO_population != '0)) begin
          count_d = FIFO_population;
          index_d = '0;
          state_d = READ;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        token_d = input_token;
        state_d = WRITE;
      end
      WRITE: begin
        if (index_q == (count_q - AW'(1))) begin
          state_d = END;
        end else begin
          index_d = index_q + AW'(1);
          state_d = READ;
        end
      end
      END: begin
        if (!start_in) begin
          index_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so each strobe lines up
    // exactly with the cycle spent in its state, with no input-to-output path.
    rd_en_d = (state_d == READ);
    wr_en_d = (state_d == WRITE);
    done_d  = (state_d == END);
    addr_d  = addr_q;
    if (state_d == WRITE) begin
      addr_d = index_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      addr_q  <= '0;
      token_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      token_q <= token_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
    end
  end

  assign FIFO_rd_en   = rd_en_q;
  assign ram_wr_en    = wr_en_q;
  assign ram_wr_addr  = addr_q;
  assign output_token = token_q;

`ifdef MEM_LOAD_DONE_EN
  assign done = done_q;
`else
  logic unused_done;
  assign unused_done = done_q;
`endif

endmodule

// File: tb/tb_mem_load_controller.sv
// tb_mem_load_controller
//   Directed bench for mem_load_controller with a behavioural FIFO and RAM.
module tb_mem_load_controller;

  logic        clk;
  logic        rst_n;
  logic [9:0]  fifo_level;
  logic [15:0] input_token;
  logic        start_in;
  logic        FIFO_rd_en;
  logic        ram_wr_en;
  logic [9:0]  ram_wr_addr;
  logic [15:0] output_token;
`ifdef MEM_LOAD_DONE_EN
  logic        done;
`endif

  mem_load_controller #(
    .word_size  (16),
    .buffer_size(1024)
  ) dut (
    .clk            (clk),
    .rst            (rst_n),
    .FIFO_population(fifo_level),
    .input_token    (input_token),
    .start_in       (start_in),
    .FIFO_rd_en     (FIFO_rd_en),
    .ram_wr_en      (ram_wr_en),
    .ram_wr_addr    (ram_wr_addr),
    .output_token   (output_token)
`ifdef MEM_LOAD_DONE_EN
    ,
    .done           (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] fifo_q[$];
  logic [15:0] ram[1024];
  int          addr_log[$];
  int          cyc;
  int          rd_pulses;
  int          wr_cnt;
  int          last_wr_cyc;
  int          overlap;
  int          n_tests;
  int          n_fail;

  // FIFO and RAM models: both act on the rising edge like the real blocks.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (FIFO_rd_en && ram_wr_en) overlap = overlap + 1;
    if (FIFO_rd_en) begin
      rd_pulses = rd_pulses + 1;
      if (fifo_q.size() != 0) input_token <= fifo_q.pop_front();
      fifo_level = 10'(fifo_q.size());
    end
    if (ram_wr_en) begin
      ram[ram_wr_addr] = output_token;
      wr_cnt           = wr_cnt + 1;
      last_wr_cyc      = cyc;
      addr_log.push_back(int'(ram_wr_addr));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    fifo_q.push_back(v);
    fifo_level = 10'(fifo_q.size());
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd"},   32'(FIFO_rd_en),   0);
    check({tag, "_wr"},   32'(ram_wr_en),    0);
    check({tag, "_addr"}, 32'(ram_wr_addr),  0);
    check({tag, "_data"}, 32'(output_token), 0);
  endtask

  int rd_base;
  int wr_base;
  int start_cyc;
  bit found;

  initial begin
    cyc         = 0;
    rd_pulses   = 0;
    wr_cnt      = 0;
    last_wr_cyc = 0;
    overlap     = 0;
    n_tests     = 0;
    n_fail      = 0;
    fifo_level  = '0;
    input_token = '0;
    start_in    = 1'b0;
    rst_n       = 1'b0;
    for (int i = 0; i < 1024; i++) ram[i] = '0;

    // Reset state
    tick(3);
    check_outputs_zero("reset");
`ifdef MEM_LOAD_DONE_EN
    check("reset_done", 32'(done), 0);
`endif
    rst_n = 1'b1;
    tick(2);

    // Three-token load with start held high for 50 cycles
    push(16'd10); push(16'd20); push(16'd30);
    rd_base   = rd_pulses;
    wr_base   = wr_cnt;
    start_cyc = cyc + 1;
    start_in  = 1'b1;
    tick(50);
    check("t1_rd_pulses", 32'(rd_pulses - rd_base), 3);
    check("t1_writes",    32'(wr_cnt - wr_base),    3);
    check("t1_ram0",      32'(ram[0]), 10);
    check("t1_ram1",      32'(ram[1]), 20);
    check("t1_ram2",      32'(ram[2]), 30);
    check("t1_latency",   32'(last_wr_cyc - start_cyc), 9);
    check("t1_fifo_empty", 32'(fifo_level), 0);
`ifdef MEM_LOAD_DONE_EN
    check("t1_done", 32'(done), 1);
`endif

    // New tokens while start is still held: no second load
    push(16'd7); push(16'd8);
    tick(10);
    check("hold_no_writes", 32'(wr_cnt - wr_base), 3);
    check("hold_fifo_kept", 32'(fifo_level), 2);
    start_in = 1'b0;
    tick(2);
`ifdef MEM_LOAD_DONE_EN
    check("hold_done_low", 32'(done), 0);
`endif
    start_in = 1'b1;
    tick(20);
    check("hold_writes", 32'(wr_cnt - wr_base), 5);
    check("hold_ram0", 32'(ram[0]), 7);
    check("hold_ram1", 32'(ram[1]), 8);
    start_in = 1'b0;
    tick(2);

    // Six-token load, write addresses must step 0..5
    for (int k = 1; k <= 6; k++) push(16'(k * 100));
    addr_log.delete();
    wr_base  = wr_cnt;
    start_in = 1'b1;
    tick(30);
    check("t2_writes", 32'(wr_cnt - wr_base), 6);
    check("t2_addr_count", 32'(addr_log.size()), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_ram%0d", k), 32'(ram[k]), 32'((k + 1) * 100));
      if (k < addr_log.size()) check($sformatf("t2_addr%0d", k), 32'(addr_log[k]), 32'(k));
    end
    start_in = 1'b0;
    tick(2);

    // Empty FIFO: request must be ignored
    rd_base  = rd_pulses;
    wr_base  = wr_cnt;
    start_in = 1'b1;
    tick(10);
    check("empty_rd",  32'(rd_pulses - rd_base), 0);
    check("empty_wr",  32'(wr_cnt - wr_base),    0);
    check("empty_rd_now", 32'(FIFO_rd_en), 0);
    start_in = 1'b0;
    tick(2);

    // Reset during the second WRITE of a six-token load
    for (int k = 1; k <= 6; k++) push(16'(1000 + k));
    rd_base  = rd_pulses;
    start_in = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (ram_wr_en && ram_wr_addr == 10'd1) found = 1'b1;
    end
    check("rst_reached_write2", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    tick(2);
    check("rst_ram0", 32'(ram[0]), 1001);
    for (int k = 2; k < 6; k++) check($sformatf("rst_ram%0d", k), 32'(ram[k]), 32'((k + 1) * 100));
    check("rst_rd_pulses", 32'(rd_pulses - rd_base), 2);
    check("rst_fifo_left", 32'(fifo_level), 4);
    start_in = 1'b0;
    fifo_q.delete();
    fifo_level = '0;
    rst_n = 1'b1;
    tick(3);
    check_outputs_zero("rst_after");

    // Snapshot: tokens arriving mid-load stay in the FIFO
    push(16'd41); push(16'd42); push(16'd43);
    rd_base  = rd_pulses;
    wr_base  = wr_cnt;
    start_in = 1'b1;
    tick(1);
    for (int k = 1; k <= 5; k++) begin
      push(16'(50 + k));
      tick(1);
    end
    tick(20);
    check("snap_writes", 32'(wr_cnt - wr_base), 3);
    check("snap_rd",     32'(rd_pulses - rd_base), 3);
    check("snap_ram0",   32'(ram[0]), 41);
    check("snap_ram1",   32'(ram[1]), 42);
    check("snap_ram2",   32'(ram[2]), 43);
    check("snap_fifo_left", 32'(fifo_level), 5);
    start_in = 1'b0;
    tick(2);

    check("no_rd_wr_overlap", 32'(overlap), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
